delay_align_ctrl: RTL and testbench

Automatic delay-alignment controller for the 13-bit signed programmable shift register in the ADC channel datapath. On request, it sweeps the shift register's `tap` input across a configured range. At each tap it waits for the pipeline to settle, then accumulates the sum of absolute differences (SAD) between the delayed channel and a reference channel. It then programs the tap with the lowest SAD. When idle, it passes manual tap/bypass settings through, so it is the sole driver of the shift register's `tap` and `sr_bypass` inputs.

---
 rtl/delay_align_pkg.sv | 22 ++
 rtl/delay_align_ctrl_sad_accum.sv | 50 +++++
 rtl/delay_align_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_delay_align_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_align_pkg.sv
// Shared types and constants for the delay-alignment controller.
package delay_align_pkg;

    localparam int TAP_W    = 5;
    localparam int SAMPLE_W = 13;

    // Scan controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_FINAL   = 3'd5
    } state_t;

    // SAD width: 14-bit |diff| plus LOG2_N bits of growth, so N samples never overflow.
    function automatic int sad_width(input int log2_n);
        return 14 + log2_n;
    endfunction

endpackage

// File: rtl/delay_align_ctrl_sad_accum.sv
// Sum of absolute differences: one register stage for |a-b|, then a
// clear/enable accumulator. The enable is delayed along with the |a-b| stage,
// and the sad output already folds in the sample still sitting in that stage.
// The caller can therefore compare on the cycle right after its last enable.
module sad_accum
    import delay_align_pkg::*;
#(
    parameter int SAD_W = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic        [SAD_W-1:0]    sad
);

    logic signed [SAMPLE_W:0] diff;
    logic        [SAMPLE_W:0] absd_d;
    logic        [SAMPLE_W:0] absd_q;
    logic                     en_q;
    logic        [SAD_W-1:0]  acc_q;

    // 14-bit signed difference and its magnitude (range 0..8191).
    always_comb begin
        diff   = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
        absd_d = diff[SAMPLE_W] ? -diff : diff;
    end

    // Pipeline the magnitude and the enable, then accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            absd_q <= '0;
            en_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            absd_q <= absd_d;
            en_q   <= en;
            if (clr) begin
                acc_q <= '0;
            end else if (en_q) begin
                acc_q <= acc_q + SAD_W'(absd_q);
            end
        end
    end

    assign sad = acc_q + (en_q ? SAD_W'(absd_q) : '0);

endmodule

// File: rtl/delay_align_ctrl.sv
// Delay-alignment controller: sweeps the shift-register tap over
// [TAP_MIN, TAP_MAX], measures SAD against the reference channel at each tap
// and programs the tap with the lowest SAD. When idle it passes the manual
// tap/bypass through (or holds the scan result), so it alone drives the
// shift register's tap and sr_bypass inputs.
//
// Handshake: start is a request pulse accepted only in IDLE (busy low); busy
// is high from the cycle after acceptance through the last COMPARE; done
// pulses for exactly one cycle (the FINAL state) with busy already low.
// A start seen during a scan, including the done cycle, is dropped.
//
// Per tap: APPLY (1) + SETTLE + ACCUM (N) + COMPARE (1). The sampled window is
// the N cycles after the SETTLE cycles that follow APPLY; the |a-b| register
// inside sad_accum is hidden by letting the compare read the in-flight sample.
module delay_align_ctrl
    import delay_align_pkg::*;
#(
    parameter int LOG2_N  = 8,
    parameter int SETTLE  = 4,
    parameter int TAP_MIN = 0,
    parameter int TAP_MAX = 31
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [TAP_W-1:0]               manual_tap,
    input  logic                           manual_bypass,
    input  logic                           use_manual,
    input  logic signed [SAMPLE_W-1:0]     ref_din,
    input  logic signed [SAMPLE_W-1:0]     sr_dout,
    output logic [TAP_W-1:0]               tap,
    output logic                           sr_bypass,
    output logic                           busy,
    output logic                           done,
    output logic [TAP_W-1:0]               best_tap,
    output logic [sad_width(LOG2_N)-1:0]   best_sad,
    output state_t                         dbg_state
);

    localparam int SAD_W   = sad_width(LOG2_N);
    localparam int N       = 1 << LOG2_N;
    localparam int CNT_MAX = (SETTLE > N) ? SETTLE : N;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   cur_tap_q, cur_tap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               bypass_q, bypass_d;
    logic [TAP_W-1:0]   best_tap_q, best_tap_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic               valid_q, valid_d;
    logic               acc_clr;
    logic               acc_en;
    logic [SAD_W-1:0]   sad;

    sad_accum #(
        .SAD_W (SAD_W)
    ) u_sad (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (ref_din),
        .b   (sr_dout),
        .sad (sad)
    );

    // State register and all registered outputs; reset gives bypass on, tap 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_tap_q  <= '0;
            cnt_q      <= '0;
            tap_q      <= '0;
            bypass_q   <= 1'b1;
            best_tap_q <= '0;
            best_sad_q <= '1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_tap_q  <= cur_tap_d;
            cnt_q      <= cnt_d;
            tap_q      <= tap_d;
            bypass_q   <= bypass_d;
            best_tap_q <= best_tap_d;
            best_sad_q <= best_sad_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state logic; tap/bypass are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        cur_tap_d  = cur_tap_q;
        cnt_d      = cnt_q;
        tap_d      = tap_q;
        bypass_d   = bypass_q;
        best_tap_d = best_tap_q;
        best_sad_d = best_sad_q;
        valid_d    = valid_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_APPLY;
                    cur_tap_d  = TAP_W'(TAP_MIN);
                    best_tap_d = TAP_W'(TAP_MIN);
                    best_sad_d = '1;
                    tap_d      = TAP_W'(TAP_MIN);
                    bypass_d   = 1'b0;
                end else if (use_manual || !valid_q) begin
                    tap_d    = manual_tap;
                    bypass_d = manual_bypass;
                end else begin
                    tap_d    = best_tap_q;
                    bypass_d = 1'b0;
                end
            end
            ST_APPLY: begin
                busy    = 1'b1;
                acc_clr = 1'b1;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACCUM: begin
                busy   = 1'b1;
                acc_en = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMPARE: begin
                busy = 1'b1;
                // Strict less-than: on ties the earlier (lower) tap is kept.
                if (sad < best_sad_q) begin
                    best_sad_d = sad;
                    best_tap_d = cur_tap_q;
                end
                if (cur_tap_q == TAP_W'(TAP_MAX)) begin
                    state_d = ST_FINAL;
                    tap_d   = best_tap_d;
                end else begin
                    cur_tap_d = cur_tap_q + TAP_W'(1);
                    tap_d     = cur_tap_q + TAP_W'(1);
                    state_d   = ST_APPLY;
                end
            end
            ST_FINAL: begin
                done    = 1'b1;
                valid_d = 1'b1;
                state_d = ST_IDLE;
                if (use_manual) begin
                    tap_d    = manual_tap;
                    bypass_d = manual_bypass;
                end else begin
                    tap_d    = best_tap_q;
                    bypass_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tap       = tap_q;
    assign sr_bypass = bypass_q;
    assign best_tap  = best_tap_q;
    assign best_sad  = best_sad_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_delay_align_ctrl.sv
// Bench for delay_align_ctrl: three instances with different parameter sets
// (ramp/known-delay, randomized small sweep, default-size extreme values).
module tb_delay_align_ctrl;
    import delay_align_pkg::*;

    // Instance A: LOG2_N=4, SETTLE=4, taps 0..31 -> 22 cycles per tap.
    localparam int A_LEN    = 705;
    // Instance B: LOG2_N=3, SETTLE=3, taps 3..9 -> 13 cycles per tap, 7 taps.
    localparam int B_MIN    = 3;
    localparam int B_N      = 8;
    localparam int B_SETTLE = 3;
    localparam int B_P      = 13;
    localparam int B_T      = 7;
    localparam int B_LEN    = 92;
    // Instance D: defaults.
    localparam int D_LEN    = 8385;

    typedef struct {
        logic [4:0] mtap;
        logic       mbyp;
        logic       use_m;
        logic [4:0] exp_tap;
        logic       exp_byp;
    } idle_vec_t;

    logic clk;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instance A signals
    logic rst_a, start_a, mbyp_a, use_a, byp_a, busy_a, done_a;
    logic [4:0] mtap_a, tap_a, btap_a;
    logic [17:0] bsad_a;
    logic signed [12:0] ref_a, sr_a, a_ref_val, a_sr_val;
    logic a_ramp;
    state_t st_a;
    // Instance B signals
    logic rst_b, start_b, mbyp_b, use_b, byp_b, busy_b, done_b;
    logic [4:0] mtap_b, tap_b, btap_b;
    logic [16:0] bsad_b;
    logic signed [12:0] ref_b, sr_b;
    state_t st_b;
    // Instance D signals
    logic rst_d, start_d, mbyp_d, use_d, byp_d, busy_d, done_d;
    logic [4:0] mtap_d, tap_d, btap_d;
    logic [21:0] bsad_d;
    logic signed [12:0] ref_d, sr_d;
    state_t st_d;

    delay_align_ctrl #(.LOG2_N(4), .SETTLE(4), .TAP_MIN(0), .TAP_MAX(31)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .manual_tap(mtap_a),
        .manual_bypass(mbyp_a), .use_manual(use_a), .ref_din(ref_a),
        .sr_dout(sr_a), .tap(tap_a), .sr_bypass(byp_a), .busy(busy_a),
        .done(done_a), .best_tap(btap_a), .best_sad(bsad_a), .dbg_state(st_a));

    delay_align_ctrl #(.LOG2_N(3), .SETTLE(B_SETTLE), .TAP_MIN(B_MIN), .TAP_MAX(9)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .manual_tap(mtap_b),
        .manual_bypass(mbyp_b), .use_manual(use_b), .ref_din(ref_b),
        .sr_dout(sr_b), .tap(tap_b), .sr_bypass(byp_b), .busy(busy_b),
        .done(done_b), .best_tap(btap_b), .best_sad(bsad_b), .dbg_state(st_b));

    delay_align_ctrl dut_d (
        .clk(clk), .rst(rst_d), .start(start_d), .manual_tap(mtap_d),
        .manual_bypass(mbyp_d), .use_manual(use_d), .ref_din(ref_d),
        .sr_dout(sr_d), .tap(tap_d), .sr_bypass(byp_d), .busy(busy_d),
        .done(done_d), .best_tap(btap_d), .best_sad(bsad_d), .dbg_state(st_d));

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    // ---------------- channel model for instance A ----------------
    // The channel leads the reference ramp by 12 samples; the modelled shift
    // register delays it by `tap` cycles (taps 0 and 1 both give zero delay).
    function automatic logic signed [12:0] ramp(input int t);
        logic [12:0] u;
        u = 13'(t & 32'h0000_0fff);
        return $signed(u) - 13'sd2048;
    endfunction

    function automatic int sr_delay(input logic [4:0] t);
        return (t < 5'd2) ? 0 : int'(t);
    endfunction

    always_comb begin
        if (a_ramp) begin
            ref_a = ramp(cyc);
            sr_a  = ramp(cyc + 12 - sr_delay(tap_a));
        end else begin
            ref_a = a_ref_val;
            sr_a  = a_sr_val;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_idle_vec(input idle_vec_t v, input string tag);
        mtap_a = v.mtap;
        mbyp_a = v.mbyp;
        use_a  = v.use_m;
        @(negedge clk);
        check({tag, "_tap"}, longint'(tap_a), longint'(v.exp_tap));
        check({tag, "_byp"}, longint'(byp_a), longint'(v.exp_byp));
    endtask

    // Starts a scan on A; returns negedges from the start cycle to done (-1 on timeout).
    task automatic scan_a(output int len);
        len = -1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_after_start", longint'(busy_a), 1);
        check("a_tap_after_start", longint'(tap_a), 0);
        for (int k = 2; k <= A_LEN + 20; k++) begin
            @(negedge clk);
            if (done_a) begin
                len = k;
                break;
            end
        end
        if (len < 0) check("a_done_timeout", 0, 1);
    endtask

    task automatic drive_b(input int amp, input bit same, output int r, output int s);
        r = int'($urandom_range(0, 2 * amp)) - amp;
        s = same ? r : int'($urandom_range(0, 2 * amp)) - amp;
        ref_b = 13'(r);
        sr_b  = 13'(s);
    endtask

    // Randomized scan on B, checked against a window-based SAD model.
    task automatic scan_b(input int amp, input bit same);
        int     rr[];
        int     ss[];
        int     len;
        int     exp_tap;
        longint exp_sad;
        longint sad;
        logic   u;
        logic [4:0] mt;
        logic   mb;
        rr = new[B_LEN + 1];
        ss = new[B_LEN + 1];
        len = -1;
        start_b = 1'b1;
        drive_b(amp, same, rr[0], ss[0]);
        for (int k = 1; k <= B_LEN + 10; k++) begin
            @(negedge clk);
            start_b = (k == 40);
            if (k == 1) begin
                check("b_busy_after_start", longint'(busy_b), 1);
                check("b_tap_after_start", longint'(tap_b), B_MIN);
            end
            if (done_b) begin
                len = k;
                break;
            end
            if (k <= B_LEN) drive_b(amp, same, rr[k], ss[k]);
        end
        // Reference: SAD over each tap's N-sample window, lowest wins, ties to lower tap.
        exp_tap = B_MIN;
        exp_sad = (64'd1 << 17) - 1;
        for (int i = 0; i < B_T; i++) begin
            sad = 0;
            for (int j = 1; j <= B_N; j++) begin
                int idx;
                int dv;
                idx = 1 + i * B_P + B_SETTLE + j;
                dv  = rr[idx] - ss[idx];
                sad += (dv < 0) ? -dv : dv;
            end
            if (sad < exp_sad) begin
                exp_sad = sad;
                exp_tap = B_MIN + i;
            end
        end
        check("b_scan_len", len, B_LEN);
        check("b_best_tap", longint'(btap_b), exp_tap);
        check("b_best_sad", longint'(bsad_b), exp_sad);
        check("b_final_tap", longint'(tap_b), exp_tap);
        check("b_final_byp", longint'(byp_b), 0);
        check("b_final_busy", longint'(busy_b), 0);
        // start in the done cycle must be ignored.
        u  = 1'($urandom_range(0, 1));
        mt = 5'($urandom_range(0, 31));
        mb = 1'($urandom_range(0, 1));
        start_b = 1'b1;
        use_b = u;
        mtap_b = mt;
        mbyp_b = mb;
        @(negedge clk);
        start_b = 1'b0;
        check("b_start_in_done_busy", longint'(busy_b), 0);
        check("b_start_in_done_state", longint'(st_b), longint'(ST_IDLE));
        @(negedge clk);
        check("b_idle_tap", longint'(tap_b), u ? longint'(mt) : longint'(exp_tap));
        check("b_idle_byp", longint'(byp_b), u ? longint'(mb) : 0);
    endtask

    // ---------------- main sequence ----------------
    idle_vec_t pre_v[5];
    idle_vec_t post_v[4];

    initial begin
        int len;
        pre_v[0] = '{mtap: 5'd7,  mbyp: 1'b0, use_m: 1'b0, exp_tap: 5'd7,  exp_byp: 1'b0};
        pre_v[1] = '{mtap: 5'd3,  mbyp: 1'b1, use_m: 1'b1, exp_tap: 5'd3,  exp_byp: 1'b1};
        pre_v[2] = '{mtap: 5'd31, mbyp: 1'b0, use_m: 1'b1, exp_tap: 5'd31, exp_byp: 1'b0};
        pre_v[3] = '{mtap: 5'd0,  mbyp: 1'b1, use_m: 1'b0, exp_tap: 5'd0,  exp_byp: 1'b1};
        pre_v[4] = '{mtap: 5'd12, mbyp: 1'b0, use_m: 1'b0, exp_tap: 5'd12, exp_byp: 1'b0};
        // After a scan that found tap 12: use_manual selects manual vs result.
        post_v[0] = '{mtap: 5'd5,  mbyp: 1'b1, use_m: 1'b1, exp_tap: 5'd5,  exp_byp: 1'b1};
        post_v[1] = '{mtap: 5'd9,  mbyp: 1'b0, use_m: 1'b0, exp_tap: 5'd12, exp_byp: 1'b0};
        post_v[2] = '{mtap: 5'd20, mbyp: 1'b1, use_m: 1'b0, exp_tap: 5'd12, exp_byp: 1'b0};
        post_v[3] = '{mtap: 5'd2,  mbyp: 1'b0, use_m: 1'b1, exp_tap: 5'd2,  exp_byp: 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rst_d = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_d = 1'b0;
        mtap_a = 5'd0; mtap_b = 5'd0; mtap_d = 5'd0;
        mbyp_a = 1'b0; mbyp_b = 1'b0; mbyp_d = 1'b0;
        use_a = 1'b0; use_b = 1'b0; use_d = 1'b0;
        a_ramp = 1'b0; a_ref_val = '0; a_sr_val = '0;
        ref_b = '0; sr_b = '0; ref_d = '0; sr_d = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_a_tap", longint'(tap_a), 0);
        check("rst_a_byp", longint'(byp_a), 1);
        check("rst_a_busy", longint'(busy_a), 0);
        check("rst_a_done", longint'(done_a), 0);
        check("rst_a_best_tap", longint'(btap_a), 0);
        check("rst_a_best_sad", longint'(bsad_a), 18'h3ffff);
        check("rst_a_state", longint'(st_a), longint'(ST_IDLE));
        check("rst_b_byp", longint'(byp_b), 1);
        check("rst_b_best_sad", longint'(bsad_b), 17'h1ffff);
        check("rst_b_state", longint'(st_b), longint'(ST_IDLE));
        check("rst_d_tap", longint'(tap_d), 0);
        check("rst_d_best_sad", longint'(bsad_d), 22'h3fffff);
        check("rst_d_state", longint'(st_d), longint'(ST_IDLE));
        rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0;

        // Idle passthrough before any scan (table-driven)
        for (int i = 0; i < 5; i++) apply_idle_vec(pre_v[i], "pre_idle");

        // Known delay: ramp with 12-cycle lead
        use_a = 1'b0;
        a_ramp = 1'b1;
        scan_a(len);
        check("a_ramp_len", len, A_LEN);
        check("a_ramp_done", longint'(done_a), 1);
        check("a_ramp_best_tap", longint'(btap_a), 12);
        check("a_ramp_best_sad", longint'(bsad_a), 0);
        check("a_ramp_final_tap", longint'(tap_a), 12);
        check("a_ramp_final_byp", longint'(byp_a), 0);
        check("a_ramp_final_busy", longint'(busy_a), 0);
        @(negedge clk);
        check("a_ramp_done_one_cycle", longint'(done_a), 0);
        check("a_ramp_idle_tap", longint'(tap_a), 12);
        for (int i = 0; i < 4; i++) apply_idle_vec(post_v[i], "post_idle");

        // Tie: all SADs zero -> TAP_MIN wins
        a_ramp = 1'b0;
        a_ref_val = 13'sd100;
        a_sr_val = 13'sd100;
        use_a = 1'b0;
        scan_a(len);
        check("a_tie_len", len, A_LEN);
        check("a_tie_best_tap", longint'(btap_a), 0);
        check("a_tie_best_sad", longint'(bsad_a), 0);
        @(negedge clk);

        // Reset in the middle of tap 5's accumulation window
        mtap_a = 5'd9;
        mbyp_a = 1'b1;
        use_a = 1'b0;
        start_a = 1'b1;
        for (int k = 1; k <= 118; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        check("a_mid_state", longint'(st_a), longint'(ST_ACCUM));
        check("a_mid_tap", longint'(tap_a), 5);
        rst_a = 1'b1;
        @(negedge clk);
        check("a_midrst_busy", longint'(busy_a), 0);
        check("a_midrst_done", longint'(done_a), 0);
        check("a_midrst_tap", longint'(tap_a), 0);
        check("a_midrst_byp", longint'(byp_a), 1);
        check("a_midrst_best_sad", longint'(bsad_a), 18'h3ffff);
        check("a_midrst_best_tap", longint'(btap_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("a_midrst_manual_tap", longint'(tap_a), 9);
        check("a_midrst_manual_byp", longint'(byp_a), 1);

        // Randomized sweeps against the reference model
        scan_b(4095, 1'b0);
        scan_b(3, 1'b0);
        scan_b(1, 1'b0);
        scan_b(500, 1'b1);
        scan_b(int'($urandom_range(1, 4095)), 1'b0);

        // Extreme values at default size, with a stray start mid-scan
        ref_d = 13'sd4095;
        sr_d = -13'sd4096;
        use_d = 1'b0;
        len = -1;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("d_busy_after_start", longint'(busy_d), 1);
        check("d_tap_after_start", longint'(tap_d), 0);
        for (int k = 2; k <= D_LEN + 20; k++) begin
            @(negedge clk);
            start_d = (k == 100);
            if (done_d) begin
                len = k;
                break;
            end
        end
        start_d = 1'b0;
        if (len < 0) check("d_done_timeout", 0, 1);
        check("d_scan_len", len, D_LEN);
        check("d_best_sad", longint'(bsad_d), 2096896);
        check("d_best_tap", longint'(btap_d), 0);
        check("d_final_tap", longint'(tap_d), 0);
        check("d_final_byp", longint'(byp_d), 0);
        @(negedge clk);
        check("d_idle_busy", longint'(busy_d), 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
